// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-word holding register for back-to-back frames.
// Define UART_TX_PARITY_EN to compile in the parity bit (odd/even selected per word).
module uart_tx_param #(
    parameter int DBIT    = 8,
    parameter int OS_TICK = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    input  logic            parity_odd,
    output logic            tx_ready,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);
    localparam int SMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shifter;
    logic [DBIT-1:0] hold;
    logic            hold_valid;
    logic            accept;
    logic            os_end;
    logic            sb_end;

`ifdef UART_TX_PARITY_EN
    // Parity is resolved when the word is sampled because the shifter loses bits as it sends.
    logic din_par;
    logic par_bit;
    logic hold_par;
    assign din_par = (^din) ^ parity_odd;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign tx_ready     = ~hold_valid;
    assign accept       = tx_start & tx_ready;
    assign tx_busy      = (state != IDLE);
    assign os_end       = s_tick && (s == SW'(OS_TICK - 1));
    assign sb_end       = s_tick && (s == SW'(SB_TICK - 1));
    assign tx_done_tick = (state == STOP) && sb_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            s          <= '0;
            n          <= '0;
            shifter    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
            hold_par   <= 1'b0;
`endif
        end else begin
            // Writes go to the holding register unless the shifter can take them on this edge.
            if (accept && state != IDLE && !(state == STOP && sb_end)) begin
                hold       <= din;
                hold_valid <= 1'b1;
`ifdef UART_TX_PARITY_EN
                hold_par   <= din_par;
`endif
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        shifter <= din;
`ifdef UART_TX_PARITY_EN
                        par_bit <= din_par;
`endif
                        s       <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (os_end) begin
                        s     <= '0;
                        n     <= '0;
                        state <= DATA;
                        tx    <= shifter[0];
                    end else if (s_tick) begin
                        s <= s + 1'b1;
                    end
                end
                DATA: begin
                    if (os_end) begin
                        s       <= '0;
                        shifter <= shifter >> 1;
                        if (n == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            n  <= n + 1'b1;
                            tx <= shifter[1];
                        end
                    end else if (s_tick) begin
                        s <= s + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (os_end) begin
                        s     <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else if (s_tick) begin
                        s <= s + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (sb_end) begin
                        s <= '0;
                        if (hold_valid) begin
                            shifter    <= hold;
                            hold_valid <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            par_bit    <= hold_par;
`endif
                            state      <= START;
                            tx         <= 1'b0;
                        end else if (accept) begin
                            shifter <= din;
`ifdef UART_TX_PARITY_EN
                            par_bit <= din_par;
`endif
                            state   <= START;
                            tx      <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else if (s_tick) begin
                        s <= s + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at DBIT=8, OS_TICK=16, SB_TICK=16.
// Frame expectations follow UART_TX_PARITY_EN the same way the design build does.
`timescale 1ns/1ps
module tb_uart_tx_param;
    logic       clk        = 1'b0;
    logic       reset_n    = 1'b1;
    logic       tx_start   = 1'b0;
    logic       s_tick     = 1'b1;
    logic [7:0] din        = 8'h00;
    logic       parity_odd = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    int vectors     = 0;
    int miscompares = 0;

    localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    uart_tx_param #(.DBIT(8), .OS_TICK(16), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_start     (tx_start),
        .s_tick       (s_tick),
        .din          (din),
        .parity_odd   (parity_odd),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    // Line bits in time order: bit 0 is the start bit; bit 10 is unused (idle) without parity.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic po);
`ifdef UART_TX_PARITY_EN
        return {1'b1, (^d) ^ po, d, 1'b0};
`else
        return {1'b1, po | 1'b1, d, 1'b0};
`endif
    endfunction

    // Called at a negedge; the write is accepted on the next posedge and returns at cycle 1's negedge.
    task automatic write_word(input logic [7:0] d, input logic po);
        tx_start   = 1'b1;
        din        = d;
        parity_odd = po;
        @(negedge clk);
        tx_start   = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        vectors++; if (tx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", tx_done_tick); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: tx=%b busy=%b want 1/0", tx, tx_busy); end
    endtask

    task automatic test_single_frame();
        logic [10:0] f;
        logic exp;
        f = 11'b11101001010;
`ifdef UART_TX_PARITY_EN
        f = 11'b10101001010;
`endif
        write_word(8'hA5, 1'b0);
        for (int k = 1; k <= FL * BT; k++) begin
            exp = f[(k - 1) / BT];
            vectors++; if (tx !== exp) begin miscompares++; $display("FAIL single_tx cycle %0d: got %b want %b", k, tx, exp); end
            vectors++; if (tx_done_tick !== (k == FL * BT)) begin miscompares++; $display("FAIL single_done cycle %0d: got %b want %b", k, tx_done_tick, k == FL * BT); end
            vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy cycle %0d: got %b want 1", k, tx_busy); end
            @(negedge clk);
        end
        vectors++; if (tx_busy !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_end: busy=%b tx=%b ready=%b want 0/1/1", tx_busy, tx, tx_ready);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  dv [3];
        logic        pv [3];
        logic [10:0] fv [3];
        logic        exp;
        dv = '{8'hA5, 8'h07, 8'h03};
        pv = '{1'b0, 1'b1, 1'b1};
`ifdef UART_TX_PARITY_EN
        fv = '{11'b10101001010, 11'b10000001110, 11'b11000000110};
`else
        // parity_odd has no effect on the line in this build
        fv = '{11'b11101001010, 11'b11000001110, 11'b11000000110};
`endif
        for (int j = 0; j < 3; j++) begin
            write_word(dv[j], pv[j]);
            for (int k = 1; k <= FL * BT; k++) begin
                exp = fv[j][(k - 1) / BT];
                vectors++; if (tx !== exp) begin miscompares++; $display("FAIL parity_tx word %0d cycle %0d: got %b want %b", j, k, tx, exp); end
                vectors++; if (tx_done_tick !== (k == FL * BT)) begin miscompares++; $display("FAIL parity_done word %0d cycle %0d: got %b", j, k, tx_done_tick); end
                @(negedge clk);
            end
            vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL parity_idle word %0d: busy=%b want 0", j, tx_busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1, f2;
        logic        exp;
        int          dones;
        f1 = frame_bits(8'h11, 1'b0);
        f2 = frame_bits(8'h22, 1'b0);
        dones = 0;
        write_word(8'h11, 1'b0);
        for (int k = 1; k <= 2 * FL * BT; k++) begin
            exp = (k <= FL * BT) ? f1[(k - 1) / BT] : f2[(k - 1 - FL * BT) / BT];
            vectors++; if (tx !== exp) begin miscompares++; $display("FAIL b2b_tx cycle %0d: got %b want %b", k, tx, exp); end
            vectors++; if (tx_done_tick !== (k == FL * BT || k == 2 * FL * BT)) begin miscompares++; $display("FAIL b2b_done cycle %0d: got %b", k, tx_done_tick); end
            if (tx_done_tick === 1'b1) dones++;
            if (k == 4 || k == 9) begin
                vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full cycle %0d: got %b want 0", k, tx_ready); end
            end
            if (k == FL * BT + 2) begin
                vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_free: got %b want 1", tx_ready); end
            end
            if (k == 3)      begin tx_start = 1'b1; din = 8'h22; end
            else if (k == 8) begin tx_start = 1'b1; din = 8'h33; end
            else             begin tx_start = 1'b0; din = 8'h00; end
            @(negedge clk);
        end
        vectors++; if (dones != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
        for (int k = 0; k < 3 * BT; k++) begin
            vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_no_third cycle %0d: tx=%b busy=%b", k, tx, tx_busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_slow_tick();
        logic [10:0] f;
        logic        exp;
        f = frame_bits(8'h3C, 1'b1);
        s_tick = 1'b0;
        write_word(8'h3C, 1'b1);
        for (int k = 1; k <= FL * 4 * BT; k++) begin
            s_tick = (k % 4 == 0);
            #1;
            exp = f[(k - 1) / (4 * BT)];
            vectors++; if (tx !== exp) begin miscompares++; $display("FAIL slow_tx cycle %0d: got %b want %b", k, tx, exp); end
            vectors++; if (tx_done_tick !== (k == FL * 4 * BT)) begin miscompares++; $display("FAIL slow_done cycle %0d: got %b", k, tx_done_tick); end
            @(negedge clk);
        end
        s_tick = 1'b1;
        #1;
        vectors++; if (tx_busy !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL slow_end: busy=%b tx=%b want 0/1", tx_busy, tx); end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [10:0] f;
        logic        exp;
        f = frame_bits(8'hC3, 1'b0);
        write_word(8'hC3, 1'b0);
        for (int k = 1; k < 70; k++) begin
            exp = f[(k - 1) / BT];
            vectors++; if (tx !== exp) begin miscompares++; $display("FAIL rst_pre_tx cycle %0d: got %b want %b", k, tx, exp); end
            if (k == 3) begin tx_start = 1'b1; din = 8'h77; end
            else        begin tx_start = 1'b0; din = 8'h00; end
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 1", tx_ready); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", tx_busy); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3 * BT; k++) begin
            vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_hold_discard cycle %0d: tx=%b busy=%b", k, tx, tx_busy); end
            @(negedge clk);
        end
        f = frame_bits(8'h5A, 1'b0);
        write_word(8'h5A, 1'b0);
        for (int k = 1; k <= FL * BT; k++) begin
            exp = f[(k - 1) / BT];
            vectors++; if (tx !== exp) begin miscompares++; $display("FAIL rst_after_tx cycle %0d: got %b want %b", k, tx, exp); end
            vectors++; if (tx_done_tick !== (k == FL * BT)) begin miscompares++; $display("FAIL rst_after_done cycle %0d: got %b", k, tx_done_tick); end
            @(negedge clk);
        end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_after_idle: busy=%b want 0", tx_busy); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_slow_tick();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter OS_TICK, default 16: s_tick count per start, data and parity bit; legal range 8..32.
REQ-003 Parameter SB_TICK, default 16: s_tick count for the stop period; 16, 24 or 32 give 1, 1.5 or 2 stop bits at OS_TICK=16.
REQ-004 Ports, in order:
  - clk  in  1  rising-edge clock.
  - reset_n  in  1  asynchronous, active-low reset.
  - tx_start  in  1  write strobe; accepted when tx_ready=1.
  - s_tick  in  1  one-cycle oversample enable from the baud generator.
  - din  in  DBIT  word to send; sampled on acceptance.
  - parity_odd  in  1  1 selects odd parity, 0 selects even; sampled with din.
  - tx_ready  out  1  holding register empty; a write is accepted.
  - tx_busy  out  1  a frame is in progress (state not IDLE).
  - tx_done_tick  out  1  one-cycle pulse when a frame's stop period ends.
  - tx  out  1  serial line, registered, idle high.

Function
REQ-005 Frame format: start bit (0), then DBIT data bits LSB first, then optional parity (REQ-016), then stop period (1).
REQ-006 States: IDLE, START, DATA, PARITY, STOP; one-hot or binary encoding is free.
REQ-007 Acceptance: rising edge with tx_start=1 and tx_ready=1.
  - Write while IDLE: din and parity_odd load the shifter directly; state becomes START; tx drives 0 from the following cycle.
  - Write while not IDLE: din and parity_odd load the single holding register; tx_ready falls the next cycle.
REQ-008 tx_ready is combinational and equals NOT hold_valid; tx_start with tx_ready=0 is ignored, with no corruption of any register.
REQ-009 Tick counter s counts s_tick pulses only; clk cycles without s_tick hold all counters.
REQ-010 START, DATA and PARITY each advance on the s_tick where s = OS_TICK-1, then clear s. DATA repeats DBIT times, with bit counter n running 0..DBIT-1 and the shifter moving right once per bit.
REQ-011 tx equals shifter bit 0 throughout DATA; each data bit lasts exactly OS_TICK s_ticks.
REQ-012 STOP ends on the s_tick where s = SB_TICK-1; tx_done_tick=1 on exactly that cycle.
REQ-013 STOP end with hold_valid=1: the holding word moves to the shifter, hold_valid clears, and the state goes straight to START with no idle-high gap beyond SB_TICK.
REQ-014 STOP end with hold_valid=0 and an accepted tx_start on the same edge: din loads the shifter and the state goes to START. Otherwise the state goes to IDLE.
REQ-015 At most one frame completes and at most one word is accepted per cycle; the word order on the line equals acceptance order.
REQ-016 Parity bit = XOR of the DBIT data bits, inverted when the stored parity_odd=1; lasts OS_TICK s_ticks.

Reset
REQ-017 reset_n=0 asynchronously forces:
  - state IDLE, s=0, n=0, shifter=0, hold_valid=0;
  - tx=1, tx_done_tick=0, tx_busy=0, tx_ready=1.
REQ-018 Reset mid-frame truncates the frame immediately and discards the holding register; the first accepted write after release sends a complete frame.

Configuration
REQ-019 Macro UART_TX_PARITY_EN, when defined, compiles in the PARITY state, the stored parity_odd bits and the REQ-016 behaviour; DATA then exits to PARITY.
REQ-020 Without UART_TX_PARITY_EN: no PARITY state exists, DATA exits directly to STOP, and the parity_odd port remains but is ignored.

Verification
REQ-021 The bench SHALL cover the following scenarios, all at DBIT=8, OS_TICK=16, SB_TICK=16, s_tick every cycle:
  - Parity compiled out; write 0xA5 from IDLE -> tx shows 0,1,0,1,0,0,1,0,1,1, each 16 cycles; one tx_done_tick at the last stop cycle; then tx_busy=0.
  - Parity compiled in; 0xA5 with parity_odd=0 -> parity bit 0. 0x07 with parity_odd=1 -> parity bit 0. 0x03 with parity_odd=1 -> parity bit 1.
  - Write 0x11 then 0x22 during 0x11's START -> tx_ready=0 after the second write; 0x22's start bit follows 0x11's stop with no extra idle; two tx_done_tick pulses.
  - Third write while the holding register is full -> ignored; only two frames appear on tx.
  - s_tick every 4th cycle -> every bit lasts 64 cycles; counters hold between ticks.
  - reset_n low during data bit 3 -> tx=1 and tx_ready=1 at once; a new 0x5A after release is sent intact.
